sti_rx: RTL

- Serial-to-parallel receiver for the STI serial stream, the receive end of the STI_DAC transmitter's so_data/so_valid output.
- Reconstructs each frame into the original 16-bit parallel word using the same length, fill, MSB-first and low-byte configuration the transmitter used.
- Flags framing errors, counts received frames, and signals completion.
- Sits on the loopback/verification path and in downstream receivers of STI traffic.

---
 rtl/sti_rx.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/sti_rx.sv
// sti_rx: serial-to-parallel receiver for the STI serial stream.
// Rebuilds each si_valid-qualified frame into a 16-bit word using the
// frame length, fill, bit-order and low-byte settings latched at frame start.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   si_data, si_valid   serial bit and frame qualifier
//   si_end              level, high from the last frame onward
//   cfg_length          00=8, 01=16, 10=24, 11=32 frame bits
//   cfg_fill            1: payload in MSBs of frame; 0: payload in LSBs
//   cfg_msb             1: MSB first; 0: LSB first
//   cfg_low             8-bit mode: 1 -> po_data[7:0], 0 -> po_data[15:8]
//   po_data, po_valid   reconstructed word and its one-cycle strobe
//   frm_err             one-cycle pulse on bit-count mismatch
//   fill_err            one-cycle pulse on a nonzero fill bit
//   rx_frames           wrapping count of good frames
//   rx_finish           sticky, set by a frame ending while si_end=1
//
// Optional feature macro: STI_RX_FILL_CHECK_EN enables fill-bit checking;
// when undefined fill_err is tied low.

module sti_rx #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             si_data,
  input  logic             si_valid,
  input  logic             si_end,
  input  logic [1:0]       cfg_length,
  input  logic             cfg_fill,
  input  logic             cfg_msb,
  input  logic             cfg_low,
  output logic [15:0]      po_data,
  output logic             po_valid,
  output logic             frm_err,
  output logic             fill_err,
  output logic [CNT_W-1:0] rx_frames,
  output logic             rx_finish
);

  localparam int unsigned SR_W    = 32;
  localparam int unsigned BCNT_W  = 6;
  localparam logic [BCNT_W-1:0] BCNT_SAT = BCNT_W'(33);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [BCNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]        len_q, len_d;
  logic              fill_q, fill_d;
  logic              msb_q, msb_d;
  logic              low_q, low_d;

  logic [15:0]       po_data_d;
  logic              po_valid_d;
  logic              frm_err_d;
  logic [CNT_W-1:0]  rx_frames_d;
  logic              rx_finish_d;

  logic [SR_W-1:0]   frame_c;
  logic [15:0]       word_c;
  logic [BCNT_W-1:0] len_bits_c;

  // Expected bit count for the latched length: 8*(len+1)
  assign len_bits_c = BCNT_W'({len_q, 3'b000}) + BCNT_W'(8);

  // Right-align the frame: MSB-first fills from bit 0 up, LSB-first from bit 31 down
  always_comb begin
    frame_c = '0;
    case (len_q)
      2'd0:    frame_c = msb_q ? {24'd0, sr_q[7:0]}  : {24'd0, sr_q[31:24]};
      2'd1:    frame_c = msb_q ? {16'd0, sr_q[15:0]} : {16'd0, sr_q[31:16]};
      2'd2:    frame_c = msb_q ? {8'd0, sr_q[23:0]}  : {8'd0, sr_q[31:8]};
      default: frame_c = sr_q;
    endcase
  end

  // Pick the 16-bit payload out of the right-aligned frame
  always_comb begin
    word_c = '0;
    case (len_q)
      2'd0:    word_c = low_q ? {8'h00, frame_c[7:0]} : {frame_c[7:0], 8'h00};
      2'd1:    word_c = frame_c[15:0];
      2'd2:    word_c = fill_q ? frame_c[23:8]  : frame_c[15:0];
      default: word_c = fill_q ? frame_c[31:16] : frame_c[15:0];
    endcase
  end

`ifdef STI_RX_FILL_CHECK_EN
  logic fill_nz_c;
  logic fill_err_d;

  // Any set bit in the fill region of a 24/32-bit frame
  always_comb begin
    fill_nz_c = 1'b0;
    case (len_q)
      2'd2:    fill_nz_c = fill_q ? (|frame_c[7:0])  : (|frame_c[23:16]);
      2'd3:    fill_nz_c = fill_q ? (|frame_c[15:0]) : (|frame_c[31:16]);
      default: fill_nz_c = 1'b0;
    endcase
  end
`else
  assign fill_err = 1'b0;
`endif

  // Next-state, datapath and output pulse generation
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    fill_d      = fill_q;
    msb_d       = msb_q;
    low_d       = low_q;
    po_data_d   = po_data;
    po_valid_d  = 1'b0;
    frm_err_d   = 1'b0;
    rx_frames_d = rx_frames;
    rx_finish_d = rx_finish;
`ifdef STI_RX_FILL_CHECK_EN
    fill_err_d  = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (si_valid) begin
          len_d   = cfg_length;
          fill_d  = cfg_fill;
          msb_d   = cfg_msb;
          low_d   = cfg_low;
          // sr is already clear in IDLE, so the first bit lands in an empty register
          sr_d    = cfg_msb ? {31'd0, si_data} : {si_data, 31'd0};
          cnt_d   = BCNT_W'(1);
          state_d = RECV;
        end
      end

      RECV: begin
        if (si_valid) begin
          sr_d = msb_q ? {sr_q[30:0], si_data} : {si_data, sr_q[31:1]};
          // Saturate so overlong frames can never alias back to a legal count
          if (cnt_q != BCNT_SAT) begin
            cnt_d = cnt_q + BCNT_W'(1);
          end
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
          sr_d    = '0;
          if (cnt_q == len_bits_c) begin
            po_valid_d  = 1'b1;
            po_data_d   = word_c;
            rx_frames_d = rx_frames + CNT_W'(1);
`ifdef STI_RX_FILL_CHECK_EN
            fill_err_d  = fill_nz_c;
`endif
          end else begin
            frm_err_d = 1'b1;
          end
          if (si_end) begin
            rx_finish_d = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      fill_q    <= 1'b0;
      msb_q     <= 1'b0;
      low_q     <= 1'b0;
      po_data   <= '0;
      po_valid  <= 1'b0;
      frm_err   <= 1'b0;
      rx_frames <= '0;
      rx_finish <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      fill_q    <= fill_d;
      msb_q     <= msb_d;
      low_q     <= low_d;
      po_data   <= po_data_d;
      po_valid  <= po_valid_d;
      frm_err   <= frm_err_d;
      rx_frames <= rx_frames_d;
      rx_finish <= rx_finish_d;
    end
  end

`ifdef STI_RX_FILL_CHECK_EN
  // Fill error strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      fill_err <= 1'b0;
    end else begin
      fill_err <= fill_err_d;
    end
  end
`endif

endmodule
